// File: rtl/folded_majority_seq.sv
// folded_majority_seq: N-input popcount >= threshold vote folded over W-bit beats; `FMAJ_COUNT_OUT_EN adds out_count.
// Latency: result registered 1 cycle after the final beat is accepted; sustains one vector per BEATS cycles.
// Backpressure: in_ready = !out_valid || out_ready; a held result stalls input and freezes all outputs.
module folded_majority_seq #(
    parameter int N = 47,
    parameter int W = 8,
    localparam int CW = $clog2(N + 2),
    localparam int BEATS = (N + W - 1) / W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic          in_last,
    input  logic [CW-1:0] cfg_thresh,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_maj,
`ifdef FMAJ_COUNT_OUT_EN
    output logic [CW-1:0] out_count,
`endif
    output logic          out_err
);

    localparam int LAST_BITS = N - (BEATS - 1) * W;
    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t        state, state_nxt;
    logic [BW-1:0] beat;
    logic [CW-1:0] acc;
    logic [CW-1:0] thr;
    logic          err;

    logic          accept;
    logic          first_beat;
    logic          final_beat;
    logic [W-1:0]  masked;
    logic [CW-1:0] beat_pop;
    logic [CW-1:0] sum;
    logic [CW-1:0] thr_eff;
    logic          err_eff;

    assign out_valid  = (state == HOLD);
    assign in_ready   = !out_valid || out_ready;
    assign accept     = in_valid && in_ready;
    assign first_beat = (beat == '0);
    assign final_beat = (beat == LAST_BEAT);

    // Padding lanes above input N-1 on the final beat never vote.
    always_comb begin
        masked = '0;
        for (int i = 0; i < W; i++) begin
            masked[i] = in_data[i] && (!final_beat || (i < LAST_BITS));
        end
    end

    always_comb begin
        beat_pop = '0;
        for (int i = 0; i < W; i++) begin
            beat_pop = beat_pop + CW'(masked[i]);
        end
    end

    // Beat 0 restarts the vector, so the stale accumulator, threshold and error are bypassed.
    assign sum     = (first_beat ? '0 : acc) + beat_pop;
    assign thr_eff = first_beat ? cfg_thresh : thr;
    assign err_eff = (first_beat ? 1'b0 : err) | (in_last != final_beat);

    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM: begin
                if (accept && final_beat) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (out_ready && !(accept && final_beat)) begin
                    state_nxt = ACCUM;
                end
            end
            default: state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ACCUM;
            beat    <= '0;
            acc     <= '0;
            thr     <= '0;
            err     <= 1'b0;
            out_maj <= 1'b0;
            out_err <= 1'b0;
`ifdef FMAJ_COUNT_OUT_EN
            out_count <= '0;
`endif
        end else begin
            state <= state_nxt;
            if (accept) begin
                acc <= sum;
                thr <= thr_eff;
                err <= err_eff;
                if (final_beat) begin
                    beat    <= '0;
                    out_maj <= (sum >= thr_eff);
                    out_err <= err_eff;
`ifdef FMAJ_COUNT_OUT_EN
                    out_count <= sum;
`endif
                end else begin
                    beat <= beat + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_folded_majority_seq.sv
// Randomised and directed scoreboard bench for folded_majority_seq (N=47, W=8).
module tb_folded_majority_seq;

    localparam int N = 47;
    localparam int W = 8;
    localparam int CW = $clog2(N + 2);
    localparam int BEATS = (N + W - 1) / W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          in_last = 1'b0;
    logic [CW-1:0] cfg_thresh = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_maj;
    logic          out_err;
`ifdef FMAJ_COUNT_OUT_EN
    logic [CW-1:0] out_count;
`endif

    folded_majority_seq #(.N(N), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .cfg_thresh (cfg_thresh),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_maj    (out_maj),
`ifdef FMAJ_COUNT_OUT_EN
        .out_count  (out_count),
`endif
        .out_err    (out_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit maj;
        bit err;
        int cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   vec_start_cyc = 0;
    int   last_acc_cyc = 0;
    bit   done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: every result taken by the consumer is compared with the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("out_maj", int'(out_maj), int'(e.maj));
                chk("out_err", int'(out_err), int'(e.err));
`ifdef FMAJ_COUNT_OUT_EN
                chk("out_count", int'(out_count), e.cnt);
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [W-1:0] d, input logic l, input logic [CW-1:0] t);
        bit got = 1'b0;
        int n = 0;
        in_valid   = 1'b1;
        in_data    = d;
        in_last    = l;
        cfg_thresh = t;
        while (!got && n < 500) begin
            @(negedge clk);
            got = in_ready;
            tick();
            n++;
        end
        in_valid = 1'b0;
        if (!got) chk("beat_accept_timeout", 0, 1);
        last_acc_cyc = cyc;
    endtask

    function automatic logic [N-1:0] ones_vec(input int k);
        logic [N-1:0] v = '0;
        while ($countones(v) < k) v[$urandom_range(N - 1, 0)] = 1'b1;
        return v;
    endfunction

    // Reference: result depends only on the whole vector, the beat-0 threshold and framing flips.
    task automatic send_vec(input logic [N-1:0] v, input int thr, input logic [BEATS-1:0] flip,
                            input bit junk, input int gap);
        exp_t e;
        logic [W-1:0] d;
        for (int k = 0; k < BEATS; k++) begin
            repeat ($urandom_range(gap, 0)) tick();
            for (int i = 0; i < W; i++) begin
                if (k * W + i < N) d[i] = v[k * W + i];
                else               d[i] = junk ? 1'b1 : 1'($urandom_range(1, 0));
            end
            send_beat(d, (k == BEATS - 1) ^ flip[k], (k == 0) ? CW'(thr) : CW'($urandom));
            if (k == 0) vec_start_cyc = last_acc_cyc;
        end
        e.cnt = $countones(v);
        e.maj = (e.cnt >= thr);
        e.err = (flip != '0);
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        do_reset();
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_maj", int'(out_maj), 0);
        chk("rst_out_err", int'(out_err), 0);
`ifdef FMAJ_COUNT_OUT_EN
        chk("rst_out_count", int'(out_count), 0);
`endif
        tick();

        // Majority boundary and final-beat masking with junk padding
        send_vec(ones_vec(24), 24, '0, 1'b0, 2);
        send_vec(ones_vec(23), 24, '0, 1'b0, 2);
        send_vec('1, 24, '0, 1'b1, 0);
        repeat (3) tick();

        // Backpressure, then zero-bubble streaming of 4 vectors
        out_ready = 1'b0;
        send_vec(ones_vec(30), 24, '0, 1'b0, 0);
        chk("latency_valid", int'(out_valid), 1);
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_out_valid", int'(out_valid), 1);
            chk("bp_out_maj", int'(out_maj), 1);
            chk("bp_out_err", int'(out_err), 0);
        end
        tick();
        out_ready = 1'b1;
        send_vec(ones_vec(5), 3, '0, 1'b1, 0);
        s = vec_start_cyc;
        send_vec(ones_vec(40), 41, '0, 1'b0, 0);
        send_vec(ones_vec(0), 1, '0, 1'b1, 0);
        send_vec(ones_vec(47), 47, '0, 1'b0, 0);
        chk("stream_cycles", last_acc_cyc - s, 4 * BEATS - 1);
        repeat (3) tick();

        // Framing: last on beat 3, missing on beat 5; then a clean vector
        send_vec(ones_vec(12), 10, 6'b101000, 1'b0, 1);
        send_vec(ones_vec(12), 10, '0, 1'b0, 1);
        repeat (3) tick();

        // Reset mid-vector discards the partial count
        for (int k = 0; k < 3; k++) send_beat('1, 1'b0, CW'(24));
        do_reset();
        send_vec(ones_vec(10), 24, '0, 1'b0, 0);

        // Threshold extremes
        send_vec('0, 0, '0, 1'b0, 1);
        send_vec('1, 48, '0, 1'b1, 1);
        send_vec('1, 47, '0, 1'b0, 1);

        // Random traffic with random consumer backpressure
        done = 1'b0;
        fork
            begin
                for (int j = 0; j < 40; j++) begin
                    logic [BEATS-1:0] f;
                    f = ($urandom_range(9, 0) == 0) ? BEATS'($urandom) : '0;
                    send_vec(ones_vec($urandom_range(N, 0)), $urandom_range(N + 1, 0), f,
                             1'($urandom_range(1, 0)), 2);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    tick();
                    out_ready = ($urandom_range(3, 0) != 0);
                end
            end
        join
        out_ready = 1'b1;
        repeat (20) tick();
        chk("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/folded_majority_seq.md
# folded_majority_seq

Sequential, parametrised majority/threshold evaluator that folds an N-input vote over W-bit beats. It generalises the flat combinational majority gate to arbitrary N, adds a run-time programmable threshold and valid/ready handshakes on both sides. It sits between a streaming bit source and consumers needing `popcount(x) >= T` decisions when N is too wide for a single-cycle tree.

## Interface
- `N`, default 47: total vote inputs per vector, ≥1.
- `W`, default 8: bits per input beat, 1..N.
- `CW`, derived as `$clog2(N+2)`: count/threshold width. It holds 0..N+1.
- `BEATS`, derived as `(N+W-1)/W`: beats per vector.
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: synchronous reset, active-high.
- `in_valid`, input, 1: beat present.
- `in_ready`, output, 1: block accepts a beat.
- `in_data`, input, W: vote bits, LSB = lowest-index input of the beat.
- `in_last`, input, 1: source marks the final beat. Used for a framing check only.
- `cfg_thresh`, input, CW: threshold, sampled on beat 0 of each vector.
- `out_valid`, output, 1: result present.
- `out_ready`, input, 1: consumer takes the result.
- `out_maj`, output, 1: `count >= threshold`.
- `out_err`, output, 1: framing error for this vector.
- `out_count`, output, CW: popcount. Present only with `FMAJ_COUNT_OUT_EN`.

## Operation
- **Beat acceptance.** A beat is accepted when `in_valid && in_ready`. Beat k carries inputs k*W .. k*W+W-1.
- **Final-beat masking.** On beat BEATS-1, only the low `N-(BEATS-1)*W` bits count. Upper bits are masked and ignored.
- **Accumulator.** `acc` is CW bits. It is cleared on beat 0: `acc <= popcount(masked beat)`. On later beats, `acc <= acc + popcount(masked beat)`. It cannot overflow, since the maximum is N.
- **Beat counter.** `beat` runs 0..BEATS-1. It wraps to 0 after the final beat.
- **Threshold.** `cfg_thresh` is latched into `thr` on beat 0.
  - `thr = 0` gives `out_maj = 1` always.
  - `thr > N` gives `out_maj = 0` always.
- **Framing check.** The sticky error is set if `in_last` is 1 on a non-final beat, or 0 on the final beat. A vector always spans exactly BEATS beats, regardless of `in_last`.
- **State machine.**
  - ACCUM: accepts beats. On acceptance of the final beat, it registers `out_maj` (computed from `acc + final popcount` vs `thr`), `out_err` and `out_count`, sets `out_valid`, and goes to HOLD.
  - HOLD: `out_valid = 1` and outputs are stable. When `out_ready` is high, it returns to ACCUM, or stays in HOLD if the same cycle also completes a new vector.
- **Ready rule.** `in_ready = !out_valid || out_ready`. This allows zero-bubble streaming.
- **Simultaneous events.** When the output is taken and a final beat is accepted in the same cycle (including BEATS = 1), `out_valid` stays 1 and the outputs update to the new vector.

## Timing
- Reset values: `in_ready = 1`, `out_valid = 0`, `out_maj = 0`, `out_err = 0`, `out_count = 0`. Internal `beat = 0`, `acc = 0`, `thr = 0`, error flag = 0.
- **Reset mid-vector.** Partial accumulation is discarded. The next accepted beat is beat 0.
- **Reset over a held result.** The result is dropped.
- **Latency.** `out_valid` rises 1 cycle after the final beat is accepted.
- **Throughput.** One vector per BEATS cycles under continuous valid/ready.
- **Idle beats.** Beats with `in_valid = 0` do not advance `beat`.
- **Backpressure.** While `out_valid && !out_ready`, `in_ready = 0` and all outputs hold.
- All outputs are registered. There is no combinational path from `in_data` to outputs.
- `in_ready` depends combinationally on `out_ready` only.

## Configuration
- `FMAJ_COUNT_OUT_EN` defined: the `out_count` port exists. It carries the full vector popcount, registered with `out_maj` and reset to 0.
- `FMAJ_COUNT_OUT_EN` undefined: the port is absent. The count is used only for the compare. `out_maj` behaviour is identical in both builds.

## Test plan
All scenarios use N=47, W=8, so BEATS=6 and the final beat has 7 valid bits.
- **Majority boundary.** Vector with 24 ones, `cfg_thresh=24` -> `out_maj=1`, `out_count=24`, `out_err=0`. Same with 23 ones -> `out_maj=0`, `out_count=23`.
- **Final-beat masking.** All-ones vector with `in_data[7]=1` on beat 5 -> `out_count=47`, `out_maj=1`.
- **Backpressure then streaming.**
  - Hold `out_ready=0` for 3 cycles after a result: `in_ready=0`, outputs stable.
  - Release `out_ready`: the next vector streams with no bubble.
  - 4 back-to-back vectors complete in 24 cycles with correct results.
- **Framing error.** `in_last=1` on beat 3 and 0 on beat 5 -> `out_err=1`. The vector still completes after 6 beats. The next correctly framed vector gives `out_err=0`.
- **Reset mid-vector.** `rst` after 3 beats of all-ones, then a 10-ones vector -> `out_count=10`, `out_maj=0` at `thr=24`.
- **Threshold extremes.** `cfg_thresh=0` with all zeros -> `out_maj=1`. `cfg_thresh=48` with all ones -> `out_maj=0`. Changing `cfg_thresh` mid-vector has no effect.
